// File: rtl/stat_response_misr_if.sv
// Response handshake bundle between a Stat_* benchmark harness and the MISR.
// resp_mask exists only when MISR_XMASK_EN is defined.
interface stat_response_misr_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
`ifdef MISR_XMASK_EN
    logic [WIDTH-1:0] resp_mask;

    modport master (output resp_valid, output resp_data, output resp_mask, input resp_ready);
    modport slave  (input resp_valid, input resp_data, input resp_mask, output resp_ready);
`else
    modport master (output resp_valid, output resp_data, input resp_ready);
    modport slave  (input resp_valid, input resp_data, output resp_ready);
`endif
endinterface

// File: rtl/stat_response_misr.sv
// MISR response compactor: folds PATTERN_COUNT benchmark words, then compares to golden.
// Optional feature macro MISR_XMASK_EN zeroes masked response bits before compaction.
module stat_response_misr #(
    parameter int unsigned      WIDTH         = 32,
    parameter logic [WIDTH-1:0] POLY          = WIDTH'(32'h04C11DB7),
    parameter logic [WIDTH-1:0] SEED          = '0,
    parameter int unsigned      PATTERN_COUNT = 256
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    stat_response_misr_if.slave                rsp,
    input  logic [WIDTH-1:0]                   golden,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic [WIDTH-1:0]                   signature,
    output logic [$clog2(PATTERN_COUNT+1)-1:0] count
);
    localparam int unsigned   CW   = $clog2(PATTERN_COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(PATTERN_COUNT - 1);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t           state;
    logic             hs_c;
    logic [WIDTH-1:0] din_c;
    logic [WIDTH-1:0] sig_next_c;

    // Handshake controls are pure decodes of the state register.
    assign rsp.resp_ready = (state == RUN);
    assign busy           = (state == RUN) || (state == CHECK);
    assign done           = (state == DONE);
    assign hs_c           = rsp.resp_valid && (state == RUN);

    // Galois MISR step with the response word XORed in.
    always_comb begin
        din_c = rsp.resp_data;
`ifdef MISR_XMASK_EN
        din_c = rsp.resp_data & ~rsp.resp_mask;
`endif
        sig_next_c = {signature[WIDTH-2:0], 1'b0}
                   ^ (signature[WIDTH-1] ? POLY : '0)
                   ^ din_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            signature <= SEED;
            count     <= '0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        signature <= SEED;
                        count     <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (hs_c) begin
                        signature <= sig_next_c;
                        count     <= count + CW'(1);
                        if (count == LAST) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    pass  <= (signature == golden);
                    state <= DONE;
                end
                DONE: begin
                    if (start) begin
                        signature <= SEED;
                        count     <= '0;
                        pass      <= 1'b0;
                        state     <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stat_response_misr.sv
// Four MISR instances (PATTERN_COUNT 1,2,4,5) share one stimulus stream and are
// compared every cycle against a queue-based model of accepted responses.
module tb_stat_response_misr;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam int          PCS   [4] = '{1, 2, 4, 5};
    localparam logic [31:0] SEEDS [4] = '{32'h0, 32'h0, 32'h0, 32'h12345678};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = '0;
    logic [31:0] mask_v = '0;
    logic [31:0] golden = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stat_response_misr_if #(.WIDTH(32)) if0 ();
    stat_response_misr_if #(.WIDTH(32)) if1 ();
    stat_response_misr_if #(.WIDTH(32)) if2 ();
    stat_response_misr_if #(.WIDTH(32)) if3 ();

    assign if0.resp_valid = valid;  assign if0.resp_data = data;
    assign if1.resp_valid = valid;  assign if1.resp_data = data;
    assign if2.resp_valid = valid;  assign if2.resp_data = data;
    assign if3.resp_valid = valid;  assign if3.resp_data = data;
`ifdef MISR_XMASK_EN
    assign if0.resp_mask = mask_v;
    assign if1.resp_mask = mask_v;
    assign if2.resp_mask = mask_v;
    assign if3.resp_mask = mask_v;
`endif

    logic        busy_w [4];
    logic        done_w [4];
    logic        pass_w [4];
    logic [31:0] sig_w  [4];
    logic [31:0] cnt_w  [4];
    logic        rdy_w  [4];
    logic [0:0]  cnt0;
    logic [1:0]  cnt1;
    logic [2:0]  cnt2;
    logic [2:0]  cnt3;

    assign cnt_w[0] = 32'(cnt0);
    assign cnt_w[1] = 32'(cnt1);
    assign cnt_w[2] = 32'(cnt2);
    assign cnt_w[3] = 32'(cnt3);
    assign rdy_w[0] = if0.resp_ready;
    assign rdy_w[1] = if1.resp_ready;
    assign rdy_w[2] = if2.resp_ready;
    assign rdy_w[3] = if3.resp_ready;

    stat_response_misr #(.PATTERN_COUNT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .rsp(if0), .golden(golden),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .signature(sig_w[0]), .count(cnt0));
    stat_response_misr #(.PATTERN_COUNT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .rsp(if1), .golden(golden),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .signature(sig_w[1]), .count(cnt1));
    stat_response_misr #(.PATTERN_COUNT(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .rsp(if2), .golden(golden),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .signature(sig_w[2]), .count(cnt2));
    stat_response_misr #(.PATTERN_COUNT(5), .SEED(32'h12345678)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .rsp(if3), .golden(golden),
        .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .signature(sig_w[3]), .count(cnt3));

    // Model: the run is the list of accepted words; signature is their fold.
    logic [31:0] acc [4][$];
    bit          m_run  [4];
    int          m_fin  [4];   // 0: not finished, 1: comparing, 2: result ready
    bit          m_pass [4];

    function automatic logic [31:0] misr_of(logic [31:0] s0, logic [31:0] q[$]);
        logic [31:0] s = s0;
        foreach (q[k]) s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ q[k];
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                acc[i].delete();
                m_run[i]  <= 1'b0;
                m_fin[i]  <= 0;
                m_pass[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_run[i]) begin
                    if (valid) begin
                        acc[i].push_back(data & ~mask_v);
                        if (acc[i].size() == PCS[i]) begin
                            m_run[i] <= 1'b0;
                            m_fin[i] <= 1;
                        end
                    end
                end else if (m_fin[i] == 1) begin
                    m_pass[i] <= (misr_of(SEEDS[i], acc[i]) == golden);
                    m_fin[i]  <= 2;
                end else if (start) begin
                    acc[i].delete();
                    m_run[i]  <= 1'b1;
                    m_fin[i]  <= 0;
                    m_pass[i] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[u%0d] at %0t: got %h expected %h", nm, idx, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            chk("signature", i, sig_w[i], misr_of(SEEDS[i], acc[i]));
            chk("count", i, cnt_w[i], 32'(acc[i].size()));
            chk("resp_ready", i, 32'(rdy_w[i]), 32'(m_run[i]));
            chk("busy", i, 32'(busy_w[i]), 32'(m_run[i] || (m_fin[i] == 1)));
            chk("done", i, 32'(done_w[i]), 32'(m_fin[i] == 2));
            if (m_fin[i] == 2) chk("pass", i, 32'(pass_w[i]), 32'(m_pass[i]));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_all();
        for (int i = 0; i < 4; i++) begin
            chk("rst_sig", i, sig_w[i], SEEDS[i]);
            chk("rst_count", i, cnt_w[i], 32'h0);
            chk("rst_ready", i, 32'(rdy_w[i]), 32'h0);
            chk("rst_done", i, 32'(done_w[i]), 32'h0);
            chk("rst_pass", i, 32'(pass_w[i]), 32'h0);
            chk("rst_busy", i, 32'(busy_w[i]), 32'h0);
        end
    endtask

    initial begin
        step();
        step();
        chk_reset_all();
        rst_n = 1'b1;

        // Responses offered in IDLE are ignored.
        valid = 1'b1;
        for (int n = 0; n < 3; n++) begin data = $urandom; step(); end
        valid = 1'b0;
        chk("idle_count", 2, cnt_w[2], 32'h0);
        chk("idle_ready", 2, 32'(rdy_w[2]), 32'h0);

        // PATTERN_COUNT=1: single response 1, golden 1.
        golden = 32'h1;
        start = 1'b1; step(); start = 1'b0;
        valid = 1'b1; data = 32'h1; step(); valid = 1'b0;
        chk("pc1_check_done", 0, 32'(done_w[0]), 32'h0);
        chk("pc1_check_busy", 0, 32'(busy_w[0]), 32'h1);
        step();
        chk("pc1_done", 0, 32'(done_w[0]), 32'h1);
        chk("pc1_pass", 0, 32'(pass_w[0]), 32'h1);
        chk("pc1_sig", 0, sig_w[0], 32'h00000001);

        // start mid-run is ignored; then reset at count=2.
        start = 1'b1; step(); start = 1'b0;
        valid = 1'b1; data = $urandom; step(); valid = 1'b0;
        chk("midrun_count", 2, cnt_w[2], 32'h2);
        rst_n = 1'b0; step();
        chk_reset_all();
        rst_n = 1'b1;

        // PATTERN_COUNT=2: 80000000 then 0, golden off by one bit.
        golden = 32'h04C11DB6;
        start = 1'b1; step(); start = 1'b0;
        valid = 1'b1; data = 32'h80000000; step();
        data = 32'h0; step(); valid = 1'b0;
        step(); step();
        chk("pc2_sig", 1, sig_w[1], 32'h04C11DB7);
        chk("pc2_count", 1, cnt_w[1], 32'h2);
        chk("pc2_done", 1, 32'(done_w[1]), 32'h1);
        chk("pc2_pass", 1, 32'(pass_w[1]), 32'h0);

        // Alternating valid; u2 finishes only after its 4th handshake.
        for (int n = 0; n < 8; n++) begin
            valid = (n % 2 == 0); data = $urandom; step();
        end
        valid = 1'b0;
        chk("toggle_count", 2, cnt_w[2], 32'h4);

`ifdef MISR_XMASK_EN
        rst_n = 1'b0; step(); rst_n = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        valid = 1'b1; data = 32'hFFFFFFFF; mask_v = 32'hFFFF0000; step();
        valid = 1'b0; mask_v = '0;
        chk("xmask_sig", 0, sig_w[0], 32'h0000FFFF);
        step(); step();
`endif

        // Randomized traffic with occasional resets and model-derived goldens.
        for (int n = 0; n < 4000; n++) begin
            int g;
            start = ($urandom_range(0, 9) == 0);
            valid = ($urandom_range(0, 2) != 0);
            data  = $urandom;
`ifdef MISR_XMASK_EN
            mask_v = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
`endif
            g = $urandom_range(0, 4);
            golden = (g == 4) ? $urandom : misr_of(SEEDS[g], acc[g]);
            rst_n = ($urandom_range(0, 499) != 0);
            step();
            rst_n = 1'b1;
        end
        start = 1'b0;
        valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
